// File: rtl/mmio_memory_responder.sv
// Memory-side responder for the processor's strobe-based memory interface.
// Provides word storage below IO_BASE and a 16-word I/O window on top:
// IO_BASE+0 switches (read-only), IO_BASE+1 hex display register,
// IO_BASE+2 free-running cycle counter (write clears).
module mmio_memory_responder #(
    parameter int WORD_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int IO_BASE = 1008
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] read_addr,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [WORD_W-1:0] data,
    input  logic              read_clock,
    input  logic              write_clock,
    output logic [WORD_W-1:0] q,
    input  logic [17:0]       SW,
    output logic [6:0]        HEX0,
    output logic [6:0]        HEX1,
    output logic [6:0]        HEX2,
    output logic [6:0]        HEX3,
    output logic [6:0]        HEX4,
    output logic [6:0]        HEX5,
    output logic [6:0]        HEX6,
    output logic [6:0]        HEX7
);

    localparam logic [ADDR_W-1:0] MEM_TOP  = ADDR_W'(IO_BASE);
    localparam logic [ADDR_W-1:0] SW_ADDR  = ADDR_W'(IO_BASE);
    localparam logic [ADDR_W-1:0] HEX_ADDR = ADDR_W'(IO_BASE + 1);
    localparam logic [ADDR_W-1:0] CNT_ADDR = ADDR_W'(IO_BASE + 2);

    logic [WORD_W-1:0] mem [0:IO_BASE-1];
    logic [WORD_W-1:0] hex_reg;
    logic [WORD_W-1:0] counter;
    logic [17:0]       sw_meta;
    logic [17:0]       sw_sync;
    logic              rd_prev;
    logic              wr_prev;
    logic              rd_armed;
    logic              wr_armed;
    logic              rd_launch;
    logic              wr_launch;
    logic [31:0]       hex_ext;

    // A strobe launches once per 1->0 transition. The armed flags keep a
    // strobe that is already low when reset releases from launching: the
    // strobe has to be seen high at least once after reset first.
    assign rd_launch = rd_armed && rd_prev && !read_clock;
    assign wr_launch = wr_armed && wr_prev && !write_clock;

    // Strobe history and post-reset arming.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: every register is updated with <= so all blocks see the
        // pre-edge values; this is what makes simultaneous accesses read-first.
        if (reset) begin
            rd_prev  <= 1'b1;
            wr_prev  <= 1'b1;
            rd_armed <= 1'b0;
            wr_armed <= 1'b0;
        end else begin
            rd_prev <= read_clock;
            wr_prev <= write_clock;
            if (read_clock)  rd_armed <= 1'b1;
            if (write_clock) wr_armed <= 1'b1;
        end
    end

    // Word storage write port; wr_launch is held low throughout reset.
    always_ff @(posedge clock) begin
        // NOTE: the storage array has no reset branch so it maps onto RAM;
        // its contents after power-up are undefined and survive reset.
        if (wr_launch && (write_addr < MEM_TOP)) begin
            mem[write_addr] <= data;
        end
    end

    // Read decode, I/O registers, cycle counter and switch synchronizer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q       <= '0;
            hex_reg <= '0;
            counter <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= SW;
            sw_sync <= sw_meta;

            // A clear written this edge beats the increment.
            if (wr_launch && (write_addr == CNT_ADDR)) begin
                counter <= '0;
            end else begin
                counter <= counter + WORD_W'(1);
            end

            if (wr_launch && (write_addr == HEX_ADDR)) begin
                hex_reg <= data;
            end

            if (rd_launch) begin
                if (read_addr < MEM_TOP) begin
                    q <= mem[read_addr];
                end else begin
                    case (read_addr)
                        SW_ADDR:  q <= WORD_W'(sw_sync);
                        HEX_ADDR: q <= hex_reg;
                        CNT_ADDR: q <= counter;
                        default:  q <= '0;
                    endcase
                end
            end
        end
    end

    // Active-low gfedcba pattern for one hex digit.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] seg;
        // NOTE: seg gets a value on every path (full case plus default),
        // so no latch is inferred in the combinational decode.
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Narrow words are zero-extended so the unused digits show 0.
    assign hex_ext = 32'(hex_reg);

    assign HEX0 = seg7(hex_ext[3:0]);
    assign HEX1 = seg7(hex_ext[7:4]);
    assign HEX2 = seg7(hex_ext[11:8]);
    assign HEX3 = seg7(hex_ext[15:12]);
    assign HEX4 = seg7(hex_ext[19:16]);
    assign HEX5 = seg7(hex_ext[23:20]);
    assign HEX6 = seg7(hex_ext[27:24]);
    assign HEX7 = seg7(hex_ext[31:28]);

endmodule

// File: tb/tb_mmio_memory_responder.sv
// Directed self-checking bench for mmio_memory_responder.
module tb_mmio_memory_responder;

    localparam int WORD_W  = 32;
    localparam int ADDR_W  = 10;
    localparam int IO_BASE = 1008;

    localparam logic [ADDR_W-1:0] SW_A  = 10'd1008;
    localparam logic [ADDR_W-1:0] HEX_A = 10'd1009;
    localparam logic [ADDR_W-1:0] CNT_A = 10'd1010;

    logic              clock;
    logic              reset;
    logic [ADDR_W-1:0] read_addr;
    logic [ADDR_W-1:0] write_addr;
    logic [WORD_W-1:0] data;
    logic              read_clock;
    logic              write_clock;
    logic [WORD_W-1:0] q;
    logic [17:0]       SW;
    logic [6:0]        HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;

    int checks = 0;
    int errors = 0;

    mmio_memory_responder #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W),
        .IO_BASE(IO_BASE)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .read_addr  (read_addr),
        .write_addr (write_addr),
        .data       (data),
        .read_clock (read_clock),
        .write_clock(write_clock),
        .q          (q),
        .SW         (SW),
        .HEX0       (HEX0),
        .HEX1       (HEX1),
        .HEX2       (HEX2),
        .HEX3       (HEX3),
        .HEX4       (HEX4),
        .HEX5       (HEX5),
        .HEX6       (HEX6),
        .HEX7       (HEX7)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One-cycle low write strobe; commits at the following edge.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
        @(posedge clock); #1;
        write_addr  = a;
        data        = d;
        write_clock = 1'b0;
        @(posedge clock); #1;
        write_clock = 1'b1;
    endtask

    // One-cycle low read strobe; returns after the processor's sample edge.
    task automatic do_read(input logic [ADDR_W-1:0] a);
        @(posedge clock); #1;
        read_addr  = a;
        read_clock = 1'b0;
        @(posedge clock); #1;
        read_clock = 1'b1;
        @(posedge clock); #1;
    endtask

    initial begin
        reset       = 1'b1;
        read_addr   = '0;
        write_addr  = '0;
        data        = '0;
        read_clock  = 1'b1;
        write_clock = 1'b1;
        SW          = '0;

        // 1. Reset state and counter liveness.
        repeat (2) @(posedge clock);
        #1;
        check("reset_q", q, 32'h0);
        check("reset_hex0", 32'(HEX0), 32'h40);
        check("reset_hex4", 32'(HEX4), 32'h40);
        check("reset_hex7", 32'(HEX7), 32'h40);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        do_read(CNT_A);
        check("counter_small_nonzero", 32'((q > 0) && (q < 32)), 32'h1);

        // 2. Memory write/read and q hold.
        do_write(10'd5, 32'hDEADBEEF);
        do_read(10'd5);
        check("mem_rd5", q, 32'hDEADBEEF);
        do_write(10'd6, 32'h00001234);
        repeat (2) @(posedge clock);
        #1;
        check("q_hold", q, 32'hDEADBEEF);

        // 3. Hex register and display decode.
        do_write(HEX_A, 32'h0123ABCD);
        #1;
        check("hex0_d", 32'(HEX0), 32'(7'b0100001));
        check("hex1_C", 32'(HEX1), 32'(7'b1000110));
        check("hex2_b", 32'(HEX2), 32'(7'b0000011));
        check("hex3_A", 32'(HEX3), 32'(7'b0001000));
        check("hex4_3", 32'(HEX4), 32'(7'b0110000));
        check("hex5_2", 32'(HEX5), 32'(7'b0100100));
        check("hex6_1", 32'(HEX6), 32'(7'b1111001));
        check("hex7_0", 32'(HEX7), 32'(7'b1000000));
        do_read(HEX_A);
        check("hex_rd", q, 32'h0123ABCD);

        // 4. Simultaneous read and write to the same address: read-first.
        do_write(10'd7, 32'h00000011);
        @(posedge clock); #1;
        read_addr   = 10'd7;
        write_addr  = 10'd7;
        data        = 32'h00000022;
        read_clock  = 1'b0;
        write_clock = 1'b0;
        @(posedge clock); #1;
        read_clock  = 1'b1;
        write_clock = 1'b1;
        @(posedge clock); #1;
        check("rw_same_old", q, 32'h00000011);
        do_read(10'd7);
        check("rw_same_new", q, 32'h00000022);

        // 5. Switch synchronizer and read-only switch address.
        SW = 18'h2A5A5;
        repeat (3) @(posedge clock);
        #1;
        do_read(SW_A);
        check("sw_rd", q, 32'h0002A5A5);
        do_write(SW_A, 32'h0000FFFF);
        do_read(SW_A);
        check("sw_wr_ignored", q, 32'h0002A5A5);
        do_read(10'd1015);
        check("window_unused", q, 32'h0);

        // 6a. Read strobe held low four cycles launches once.
        @(posedge clock); #1;
        read_addr  = 10'd5;
        read_clock = 1'b0;
        @(posedge clock); #1;
        read_addr  = 10'd7;
        repeat (3) @(posedge clock);
        #1;
        check("held_strobe_q", q, 32'hDEADBEEF);
        read_clock = 1'b1;
        @(posedge clock); #1;
        check("held_strobe_after", q, 32'hDEADBEEF);

        // 6b. Reset during a pending write; release with strobe still low.
        do_write(10'd9, 32'h00000099);
        @(posedge clock); #1;
        write_addr  = 10'd9;
        data        = 32'h00000055;
        write_clock = 1'b0;
        reset       = 1'b1;
        #1;
        check("reset_mid_q", q, 32'h0);
        check("reset_mid_hex3", 32'(HEX3), 32'h40);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        write_clock = 1'b1;
        do_read(10'd9);
        check("reset_no_commit", q, 32'h00000099);
        do_read(10'd5);
        check("mem_survives_reset", q, 32'hDEADBEEF);
        do_read(HEX_A);
        check("hex_after_reset", q, 32'h0);

        // 6c. Counter clear then read one idle edge later.
        do_write(CNT_A, 32'hFFFFFFFF);
        do_read(CNT_A);
        check("counter_clear", q, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_memory_responder.md
Name: mmio_memory_responder

Overview:
- Memory-side responder for the processor's strobe-based memory interface (read_addr/write_addr/data/q with read_clock/write_clock strobes).
- Lives in the system clock domain, no separate memory clock: word storage for program/data plus a small memory-mapped I/O window.
- I/O window exposes the board switches, a hex-display register driving eight seven-segment digits, and a free-running cycle counter.

Parameters:
WORD_W, 32, data word width (matches processor word length)
ADDR_W, 10, address width (matches processor argument width)
IO_BASE, 1008, first address of I/O window (2^ADDR_W-16); window is IO_BASE..2^ADDR_W-1

Ports:
clock  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
read_addr  input  ADDR_W  read address; stable from one cycle before read strobe low
write_addr  input  ADDR_W  write address; stable from one cycle before write strobe low
data  input  WORD_W  write data, stable with write_addr
read_clock  input  1  read strobe, idle high; one-cycle low pulse requests a read
write_clock  input  1  write strobe, idle high; one-cycle low pulse requests a write
q  output  WORD_W  registered read data
SW  input  18  board switches, asynchronous
HEX0..HEX7  output  7 each  seven-segment digits, active-low, segment order gfedcba

Behaviour:
- Reset (async): q=0; hex_reg=0 (every HEX shows "0" = 7'b1000000); cycle counter=0; rd_prev=1, wr_prev=1; switch synchronizer=0. Storage array not reset.
- Strobe detect: rd_prev/wr_prev register the strobes each cycle. Access launches on the edge where the strobe is sampled 0 and its _prev is 1. A strobe held low further cycles does not retrigger. Each new access requires a return to 1.
- Read latency:
  - Processor drives strobe 0 at edge E0 and 1 at E1, then samples q at E2.
  - Responder launches at E1; q updated at E1, valid before E2.
  - q holds its value until the next read launch.
- Read decode:
  - addr<IO_BASE: q<=mem[addr].
  - IO_BASE+0: q<={zeros, sw_sync[17:0]}.
  - IO_BASE+1: q<=hex_reg.
  - IO_BASE+2: q<=cycle counter value before the increment of that edge.
  - Other window addresses: q<=0.
- Write decode (commits at launch edge):
  - addr<IO_BASE: mem[addr]<=data.
  - IO_BASE+1: hex_reg<=data.
  - IO_BASE+2: counter<=0; the clear wins over the increment on that edge.
  - IO_BASE+0 and other window addresses: write ignored, no side effect.
- Simultaneous read and write launch, same address: read-first. q gets the old value; new value is visible on the next read. Applies to memory and to hex_reg/counter.
- Switches: two-flop synchronizer. Read returns value sampled ≥2 cycles earlier.
- Counter: WORD_W bits, +1 every clock, wraps 2^WORD_W-1 → 0.
- Hex decode:
  - Combinational from hex_reg; HEXn shows nibble hex_reg[4n+3:4n], HEX0 least significant.
  - With WORD_W<32, missing nibbles show 0.
  - Segment patterns (active-low gfedcba):
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000
    - 4=0011001, 5=0010010, 6=0000010, 7=1111000
    - 8=0000000, 9=0010000, A=0001000, b=0000011
    - C=1000110, d=0100001, E=0000110, F=0001110
- Reset mid-access: the pending strobe is discarded; no write commits. After release, an access needs a fresh 1→0 strobe transition.
- Out-of-range: none possible; the address space is fully decoded.

Test Plan:
1. Reset, then idle 3 cycles → q=0, HEX0..HEX7=1000000, counter read at IO_BASE+2 returns small nonzero count.
2. Write 0xDEADBEEF to addr 5 (write_clock low 1 cycle), then read addr 5 → q=0xDEADBEEF at E2, held until next read.
3. Write 0x0123ABCD to IO_BASE+1 → HEX7..HEX0 show 0,1,2,3,A,b,C,d; read IO_BASE+1 returns 0x0123ABCD.
4. Read and write launched together, addr 7 holding 0x11 and data 0x22 → q=0x11; next read of 7 → 0x22.
5. SW=18'h2A5A5, wait 3 cycles, read IO_BASE → q=0x0002A5A5; write 0xFFFF to IO_BASE → next read unchanged.
6. Hold read_clock low 4 cycles → exactly one launch (q changes once). Assert reset while write_clock low → addr untouched. Write IO_BASE+2, then read next cycle → q=1.
